// File: rtl/operand_entry_pkg.sv
// Shared definitions for the calculator operand-entry stage: phase encodings and defaults.
package operand_entry_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_DB_CYCLES   = 250000;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        PH_ENTER_X   = 3'b000,
        PH_REQ_X     = 3'b001,
        PH_ENTER_Y   = 3'b010,
        PH_REQ_Y     = 3'b011,
        PH_WAIT_DONE = 3'b100
    } phase_e;

endpackage

// File: rtl/operand_entry_if.sv
// Operand handshake between the entry stage (master) and the control unit (slave).
interface operand_entry_if
    import operand_entry_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             start_x;
    logic             start_y;
    logic [WIDTH-1:0] operand;
    logic             ld_x;
    logic             ld_y;
    logic             done;

    modport master (
        output start_x, start_y, operand,
        input  ld_x, ld_y, done
    );

    modport slave (
        input  start_x, start_y, operand,
        output ld_x, ld_y, done
    );

endinterface

// File: rtl/operand_entry_btn_debounce.sv
// Pushbutton conditioner: synchronizer, stable-count debounce and rising-edge event pulse.
module operand_entry_btn_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_evt
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_evt;
    logic                   w_synced;
    logic                   w_flip;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_flip   = (w_synced != r_level) && (r_cnt == CNT_W'(DB_CYCLES - 1));

    // Level flips only after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_evt  <= w_flip && !r_level;
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= w_synced;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_evt = r_evt;

endmodule

// File: rtl/operand_entry.sv
// Calculator input stage: captures X then Y from the switches on ENTER and hands them to the control unit.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enter_btn,
    input  logic             i_clear_btn,
    input  logic [WIDTH-1:0] i_sw,
    output logic [2:0]       o_phase,
    output logic             o_overrun,
    operand_entry_if.master  bus
);

    logic             w_enter_evt;
    logic             w_clear_evt;
    phase_e           r_state;
    logic [WIDTH-1:0] r_operand;
    logic             r_start_x;
    logic             r_start_y;
    logic             r_overrun;

    operand_entry_btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CYCLES  (DB_CYCLES)
    ) u_db_enter (
        .clk  (clk),
        .rst  (rst),
        .i_btn(i_enter_btn),
        .o_evt(w_enter_evt)
    );

    operand_entry_btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CYCLES  (DB_CYCLES)
    ) u_db_clear (
        .clk  (clk),
        .rst  (rst),
        .i_btn(i_clear_btn),
        .o_evt(w_clear_evt)
    );

    // Request outputs are set/cleared on the same edge as the state change, so they track the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= PH_ENTER_X;
            r_operand <= '0;
            r_start_x <= 1'b0;
            r_start_y <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_clear_evt) begin
            r_state   <= PH_ENTER_X;
            r_operand <= '0;
            r_start_x <= 1'b0;
            r_start_y <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                PH_ENTER_X: begin
                    if (w_enter_evt) begin
                        r_operand <= i_sw;
                        r_start_x <= 1'b1;
                        r_state   <= PH_REQ_X;
                    end
                end
                PH_REQ_X: begin
                    if (w_enter_evt) r_overrun <= 1'b1;
                    if (bus.ld_x) begin
                        r_start_x <= 1'b0;
                        r_state   <= PH_ENTER_Y;
                    end
                end
                PH_ENTER_Y: begin
                    if (w_enter_evt) begin
                        r_operand <= i_sw;
                        r_start_y <= 1'b1;
                        r_state   <= PH_REQ_Y;
                    end
                end
                PH_REQ_Y: begin
                    if (w_enter_evt) r_overrun <= 1'b1;
                    if (bus.ld_y) begin
                        r_start_y <= 1'b0;
                        r_state   <= PH_WAIT_DONE;
                    end
                end
                PH_WAIT_DONE: begin
                    if (w_enter_evt) r_overrun <= 1'b1;
                    if (bus.done) r_state <= PH_ENTER_X;
                end
                default: begin
                    r_start_x <= 1'b0;
                    r_start_y <= 1'b0;
                    r_state   <= PH_ENTER_X;
                end
            endcase
        end
    end

    assign bus.start_x = r_start_x;
    assign bus.start_y = r_start_y;
    assign bus.operand = r_operand;
    assign o_phase     = r_state;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: expected output snapshots are queued, a monitor compares on every change.
module tb_operand_entry;

    typedef struct packed {
        logic [2:0] phase;
        logic       sx;
        logic       sy;
        logic [7:0] opnd;
        logic       ovr;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       enter_btn;
    logic       clear_btn;
    logic [7:0] sw;
    logic [2:0] phase;
    logic       overrun;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    operand_entry_if #(.WIDTH(8)) bus ();

    operand_entry #(
        .WIDTH      (8),
        .DB_CYCLES  (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enter_btn(enter_btn),
        .i_clear_btn(clear_btn),
        .i_sw       (sw),
        .o_phase    (phase),
        .o_overrun  (overrun),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input logic [2:0] ph, input logic sx, input logic sy,
                                input logic [7:0] op, input logic ov);
        obs_t o;
        o.phase = ph; o.sx = sx; o.sy = sy; o.opnd = op; o.ovr = ov;
        return o;
    endfunction

    task automatic expect_obs(input string nm, input obs_t o);
        exp_q.push_back(o);
        name_q.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter();
        enter_btn = 1'b1; tick(10);
        enter_btn = 1'b0; tick(10);
    endtask

    task automatic press_clear();
        clear_btn = 1'b1; tick(10);
        clear_btn = 1'b0; tick(10);
    endtask

    task automatic pulse_ld_x();
        bus.ld_x = 1'b1; tick(1); bus.ld_x = 1'b0; tick(2);
    endtask

    task automatic pulse_ld_y();
        bus.ld_y = 1'b1; tick(1); bus.ld_y = 1'b0; tick(2);
    endtask

    task automatic pulse_done();
        bus.done = 1'b1; tick(1); bus.done = 1'b0; tick(2);
    endtask

    // Bounded wait for the monitor to consume all queued expectations.
    task automatic drained(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) return;
            tick(1);
        end
        checks++;
        errors++;
        $display("FAIL drain_%s: %0d expected output changes never seen, required 0 pending", nm, exp_q.size());
        exp_q.delete();
        name_q.delete();
    endtask

    task automatic direct_check(input string nm, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    // Monitor: every change of the observable outputs must match the next queued snapshot.
    initial begin
        obs_t  prev;
        obs_t  cur;
        obs_t  e;
        string nm;
        prev = '1;
        forever begin
            @(negedge clk);
            cur = mk(phase, bus.start_x, bus.start_y, bus.operand, overrun);
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got phase=%0d startX=%b startY=%b operand=%h overrun=%b, required no change from phase=%0d startX=%b startY=%b operand=%h overrun=%b",
                             cur.phase, cur.sx, cur.sy, cur.opnd, cur.ovr,
                             prev.phase, prev.sx, prev.sy, prev.opnd, prev.ovr);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL %s: got phase=%0d startX=%b startY=%b operand=%h overrun=%b, required phase=%0d startX=%b startY=%b operand=%h overrun=%b",
                                 nm, cur.phase, cur.sx, cur.sy, cur.opnd, cur.ovr,
                                 e.phase, e.sx, e.sy, e.opnd, e.ovr);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        sw = 8'h00;
        bus.ld_x = 1'b0;
        bus.ld_y = 1'b0;
        bus.done = 1'b0;

        // 1: reset state, then idle with no buttons
        expect_obs("reset_state", mk(3'b000, 1'b0, 1'b0, 8'h00, 1'b0));
        tick(3);
        rst = 1'b0;
        tick(30);
        drained("reset");
        direct_check("idle_phase", 16'(phase), 16'h0000);
        direct_check("idle_start", 16'({bus.start_x, bus.start_y, overrun}), 16'h0000);

        // 2: bouncy enter yields one capture of 2A
        sw = 8'h2A;
        expect_obs("bouncy_capture_x", mk(3'b001, 1'b1, 1'b0, 8'h2A, 1'b0));
        for (int i = 0; i < 5; i++) begin
            enter_btn = 1'b1; tick(2);
            enter_btn = 1'b0; tick(2);
        end
        enter_btn = 1'b1; tick(12);
        drained("bouncy");
        enter_btn = 1'b0; tick(12);
        sw = 8'h77;
        tick(4);
        expect_obs("ldx_to_enter_y", mk(3'b010, 1'b0, 1'b0, 8'h2A, 1'b0));
        pulse_ld_x();
        drained("ldx");
        // stray acks outside their waiting state must do nothing
        pulse_done();
        pulse_ld_y();
        pulse_ld_x();
        expect_obs("clear_from_enter_y", mk(3'b000, 1'b0, 1'b0, 8'h00, 1'b0));
        press_clear();
        drained("clear1");

        // 3: full X=05, Y=03 sequence
        sw = 8'h05;
        expect_obs("capture_x05", mk(3'b001, 1'b1, 1'b0, 8'h05, 1'b0));
        press_enter();
        tick(6);
        expect_obs("ldx_05", mk(3'b010, 1'b0, 1'b0, 8'h05, 1'b0));
        pulse_ld_x();
        sw = 8'h03;
        expect_obs("capture_y03", mk(3'b011, 1'b0, 1'b1, 8'h03, 1'b0));
        press_enter();
        sw = 8'h99;
        tick(8);
        direct_check("starty_held", 16'(bus.start_y), 16'h0001);
        expect_obs("ldy_03", mk(3'b100, 1'b0, 1'b0, 8'h03, 1'b0));
        pulse_ld_y();
        expect_obs("done_to_enter_x", mk(3'b000, 1'b0, 1'b0, 8'h03, 1'b0));
        pulse_done();
        drained("full_seq");

        // 4: enter during REQ_Y sets overrun, clear recovers
        sw = 8'h11;
        expect_obs("capture_x11", mk(3'b001, 1'b1, 1'b0, 8'h11, 1'b0));
        press_enter();
        expect_obs("ldx_11", mk(3'b010, 1'b0, 1'b0, 8'h11, 1'b0));
        pulse_ld_x();
        sw = 8'h03;
        expect_obs("capture_y03b", mk(3'b011, 1'b0, 1'b1, 8'h03, 1'b0));
        press_enter();
        sw = 8'hFF;
        expect_obs("overrun_req_y", mk(3'b011, 1'b0, 1'b1, 8'h03, 1'b1));
        press_enter();
        expect_obs("clear_overrun", mk(3'b000, 1'b0, 1'b0, 8'h00, 1'b0));
        press_clear();
        drained("overrun");

        // 5: simultaneous clear and enter in ENTER_X
        sw = 8'h5A;
        enter_btn = 1'b1;
        clear_btn = 1'b1;
        tick(10);
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        tick(10);
        direct_check("clear_beats_enter", 16'({phase, bus.operand}), 16'h0000);

        // 6: async reset mid REQ_X, enter held through reset release
        sw = 8'hC3;
        expect_obs("capture_xC3", mk(3'b001, 1'b1, 1'b0, 8'hC3, 1'b0));
        press_enter();
        drained("pre_reset");
        expect_obs("async_reset", mk(3'b000, 1'b0, 1'b0, 8'h00, 1'b0));
        enter_btn = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 direct_check("async_startx_drop", 16'({bus.start_x, phase}), 16'h0000);
        sw = 8'h3C;
        expect_obs("held_enter_event", mk(3'b001, 1'b1, 1'b0, 8'h3C, 1'b0));
        tick(3);
        rst = 1'b0;
        tick(14);
        drained("held_enter");
        enter_btn = 1'b0;
        tick(20);
        direct_check("no_second_event", 16'({overrun, phase}), 16'h0001);

        tick(10);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d pending expectations, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
